lamp_monitor: RTL

LAMP_MONITOR -- requirements
Module: lamp_monitor

---
 rtl/lamp_monitor.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/lamp_monitor.sv
`default_nettype none
// ============================================================================
// Module      : lamp_monitor
// Description : Watches a one-hot traffic-lamp code and tracks the
//               RED -> GREEN -> YELLOW -> RED sequence. Flags short
//               phases, out-of-order phases, illegal codes and stuck
//               phases, and counts completed cycles and error events.
// Revision    : 1.0 - initial release
// ============================================================================
module lamp_monitor #(
  parameter int MIN_DWELL = 1000,
  parameter int MAX_DWELL = 70000000,
  parameter int DWELL_W   = 27
) (
  input  logic         fast_clk,
  input  logic         rst_n,
  input  logic [0:2]   light,
  input  logic         clr_cnt,
  output logic [1:0]   phase,
  output logic         locked,
  output logic         short_err,
  output logic         seq_err,
  output logic         illegal_err,
  output logic         timeout,
  output logic [15:0]  cycle_count,
  output logic [7:0]   err_count
);

  typedef enum logic [1:0] {
    ST_RED      = 2'd0,
    ST_GREEN    = 2'd1,
    ST_YELLOW   = 2'd2,
    ST_UNLOCKED = 2'd3
  } state_t;

  localparam logic [DWELL_W-1:0] c_dwell_sat = {DWELL_W{1'b1}};
  localparam logic [DWELL_W-1:0] c_max_dwell = MAX_DWELL[DWELL_W-1:0];
  localparam logic [DWELL_W:0]   c_min_len   = MIN_DWELL[DWELL_W:0];
  localparam logic [DWELL_W:0]   c_one_len   = {{DWELL_W{1'b0}}, 1'b1};

  logic [0:2]         r_s1;
  logic [0:2]         r_prev;
  logic [DWELL_W-1:0] r_dwell;
  state_t             r_state;
  logic               r_locked;
  logic               r_short;
  logic               r_seq;
  logic               r_ill;
  logic               r_tmo;
  logic [15:0]        r_cycle_count;
  logic [7:0]         r_err_count;

  logic               w_chg;
  logic [DWELL_W:0]   w_len;
  state_t             w_code;
  state_t             w_succ;
  state_t             w_next_state;
  logic               w_next_locked;
  logic               w_short;
  logic               w_seq;
  logic               w_ill;
  logic               w_tmo;
  logic               w_cyc_inc;
  logic               w_any_err;

  // A change event is seen one cycle after the new code lands in r_s1;
  // the length of the phase just ended is the dwell count plus one.
  assign w_chg     = (r_s1 != r_prev);
  assign w_len     = {1'b0, r_dwell} + c_one_len;
  assign w_any_err = w_short | w_seq | w_ill | w_tmo;
  assign w_cyc_inc = w_chg && r_locked && (r_state == ST_YELLOW) && (w_code == ST_RED);

  // Decode the sampled lamp code and the legal successor of the current phase.
  always_comb begin
    w_code = ST_UNLOCKED;
    w_succ = ST_UNLOCKED;
    case (r_s1)
      3'b100:  w_code = ST_RED;
      3'b010:  w_code = ST_GREEN;
      3'b001:  w_code = ST_YELLOW;
      default: w_code = ST_UNLOCKED;
    endcase
    case (r_state)
      ST_RED:    w_succ = ST_GREEN;
      ST_GREEN:  w_succ = ST_YELLOW;
      ST_YELLOW: w_succ = ST_RED;
      default:   w_succ = ST_UNLOCKED;
    endcase
  end

  // Next-state and error-pulse decisions. UNLOCKED only leaves on a change
  // event, so a phase that timed out is not re-adopted while the lamp sits still.
  always_comb begin
    w_next_state  = r_state;
    w_next_locked = r_locked;
    w_short       = 1'b0;
    w_seq         = 1'b0;
    w_ill         = 1'b0;
    w_tmo         = 1'b0;
    if (w_chg) begin
      w_short = r_locked && (w_len < c_min_len);
      if (r_state == ST_UNLOCKED) begin
        if (w_code != ST_UNLOCKED) begin
          w_next_state = w_code;
        end
      end else if (w_code == ST_UNLOCKED) begin
        w_ill         = 1'b1;
        w_next_state  = ST_UNLOCKED;
        w_next_locked = 1'b0;
      end else if (w_code == w_succ) begin
        w_next_state  = w_code;
        w_next_locked = 1'b1;
      end else begin
        w_seq         = 1'b1;
        w_next_state  = w_code;
        w_next_locked = 1'b0;
      end
    end else if ((r_state != ST_UNLOCKED) && (r_dwell == c_max_dwell)) begin
      w_tmo         = 1'b1;
      w_next_state  = ST_UNLOCKED;
      w_next_locked = 1'b0;
    end
  end

  // Input sampling and the saturating phase-dwell counter.
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 3'b000;
      r_prev  <= 3'b000;
      r_dwell <= '0;
    end else begin
      r_s1   <= light;
      r_prev <= r_s1;
      if (w_chg) begin
        r_dwell <= '0;
      end else if (r_dwell != c_dwell_sat) begin
        r_dwell <= r_dwell + 1'b1;
      end
    end
  end

  // Phase FSM with registered lock flag and single-cycle error pulses.
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_UNLOCKED;
      r_locked <= 1'b0;
      r_short  <= 1'b0;
      r_seq    <= 1'b0;
      r_ill    <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_locked <= w_next_locked;
      r_short  <= w_short;
      r_seq    <= w_seq;
      r_ill    <= w_ill;
      r_tmo    <= w_tmo;
    end
  end

  // Cycle and error counters; a clear wins over a same-edge increment.
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_count <= 16'd0;
      r_err_count   <= 8'd0;
    end else if (clr_cnt) begin
      r_cycle_count <= 16'd0;
      r_err_count   <= 8'd0;
    end else begin
      if (w_cyc_inc) begin
        r_cycle_count <= r_cycle_count + 16'd1;
      end
      if (w_any_err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign phase       = r_state;
  assign locked      = r_locked;
  assign short_err   = r_short;
  assign seq_err     = r_seq;
  assign illegal_err = r_ill;
  assign timeout     = r_tmo;
  assign cycle_count = r_cycle_count;
  assign err_count   = r_err_count;

endmodule
`default_nettype wire
